// File: rtl/smg_scan_ctrl_if.sv
// Frame-update handshake between a digit source and the scan controller.
interface smg_scan_ctrl_if;
  logic        upd_valid;
  logic [15:0] upd_data;
  logic        upd_ready;

  modport master (output upd_valid, output upd_data, input upd_ready);
  modport slave  (input upd_valid, input upd_data, output upd_ready);
endinterface

// File: rtl/smg_scan_ctrl.sv
// Four-digit 7-segment scan controller: walks the digit select at a fixed
// dwell, presents the selected digit value (with optional leading-zero
// blanking) and swaps in new frames only at frame boundaries.
module smg_scan_ctrl #(
  parameter int DIV_CNT = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_en,
  input  logic                  lz_blank,
  smg_scan_ctrl_if.slave        upd,
  output logic [1:0]            sel,
  output logic [3:0]            key,
  output logic                  frame_done
);

  localparam logic [15:0] DIV_LAST = 16'(DIV_CNT - 1);

  logic [15:0] cnt_r;
  logic [1:0]  sel_r;
  logic [3:0]  key_r;
  logic        frame_done_r;
  logic [15:0] disp_r;
  logic [15:0] shadow_r;
  logic        pending_r;

  logic        tick_s;
  logic        commit_s;
  logic        accept_s;
  logic [1:0]  sel_nxt_s;
  logic [15:0] disp_nxt_s;

  // Value shown for digit idx; a digit is blanked when it and every more
  // significant digit are zero. Digit 0 always shows.
  function automatic logic [3:0] pick_digit(input logic [15:0] d,
                                            input logic [1:0]  idx,
                                            input logic        lz);
    logic [3:0] nib;
    logic       zero_above;
    case (idx)
      2'd0: begin nib = d[3:0];   zero_above = 1'b0;               end
      2'd1: begin nib = d[7:4];   zero_above = (d[15:4]  == 12'h000); end
      2'd2: begin nib = d[11:8];  zero_above = (d[15:8]  == 8'h00);   end
      2'd3: begin nib = d[15:12]; zero_above = (d[15:12] == 4'h0);    end
      default: begin nib = 4'hF;  zero_above = 1'b0;               end
    endcase
    return (lz && zero_above) ? 4'hF : nib;
  endfunction

  // Next-cycle select, commit decision and the data the key must reflect.
  always_comb begin
    tick_s     = scan_en && (cnt_r == DIV_LAST);
    accept_s   = upd.upd_valid && !pending_r;
    commit_s   = tick_s && (sel_r == 2'd3) && pending_r;
    sel_nxt_s  = sel_r;
    disp_nxt_s = disp_r;
    if (tick_s) begin
      sel_nxt_s = sel_r + 2'd1;
    end else begin
      sel_nxt_s = sel_r;
    end
    if (commit_s) begin
      disp_nxt_s = shadow_r;
    end else begin
      disp_nxt_s = disp_r;
    end
  end

  // Dwell divider and digit select; both freeze while scanning is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
      sel_r <= 2'd0;
    end else if (scan_en) begin
      cnt_r <= tick_s ? 16'd0 : (cnt_r + 16'd1);
      sel_r <= sel_nxt_s;
    end
  end

  // Key follows the new select and the post-commit display contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r <= 4'hF;
    end else if (scan_en) begin
      key_r <= pick_digit(disp_nxt_s, sel_nxt_s, lz_blank);
    end else begin
      key_r <= 4'hF;
    end
  end

  // Shadow/display storage and the pending flag behind the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_r       <= 16'h0000;
      shadow_r     <= 16'h0000;
      pending_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      disp_r       <= disp_nxt_s;
      frame_done_r <= commit_s;
      if (commit_s) begin
        pending_r <= 1'b0;
      end else if (accept_s) begin
        pending_r <= 1'b1;
        shadow_r  <= upd.upd_data;
      end
    end
  end

  assign upd.upd_ready = ~pending_r;
  assign sel           = sel_r;
  assign key           = key_r;
  assign frame_done    = frame_done_r;

endmodule
